// File: rtl/mux_gate_seq.sv
// Bit-serial NOT/AND/OR/XOR sequencer: one shared 2:1 mux evaluates one result bit per clock.
// Start/busy/done handshake; y holds the last completed result until the next completion.

module mux2 (
    input  logic sel,
    input  logic in0,
    input  logic in1,
    output logic y
);
    assign y = sel ? in1 : in0;
endmodule

module mux_gate_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       op_lat;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;

    logic sel;
    logic bit_b;
    logic mux_in0;
    logic mux_in1;
    logic mux_y;

    mux2 u_mux (
        .sel (sel),
        .in0 (mux_in0),
        .in1 (mux_in1),
        .y   (mux_y)
    );

    // Each op is expressed purely by what the mux selects between, with a_lat[idx] as select.
    always_comb begin
        sel     = a_lat[idx];
        bit_b   = b_lat[idx];
        mux_in0 = 1'b0;
        mux_in1 = 1'b0;
        case (op_lat)
            2'b00: begin mux_in0 = 1'b1;  mux_in1 = 1'b0;   end
            2'b01: begin mux_in0 = 1'b0;  mux_in1 = bit_b;  end
            2'b10: begin mux_in0 = bit_b; mux_in1 = 1'b1;   end
            default: begin mux_in0 = bit_b; mux_in1 = ~bit_b; end
        endcase
        next_work      = work;
        next_work[idx] = mux_y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            idx    <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= '0;
            work   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat  <= a;
                        b_lat  <= b;
                        op_lat <= op;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work <= next_work;
                    if (idx == LAST) begin
                        y     <= next_work;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_gate_seq.sv
// Directed self-checking bench for mux_gate_seq (WIDTH=8) with hand-computed results.

module tb_mux_gate_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] y;

    int checks = 0;
    int errors = 0;
    int donecnt = 0;
    logic [7:0] prev_y;

    mux_gate_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) donecnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, checking busy/done timing, y stability during RUN, and the result.
    task automatic run_cmd(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] exp, input bit disturb, input string tag);
        int d0;
        d0 = donecnt;
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_done_e0"}, done, 0);
        for (int i = 1; i < 8; i++) begin
            if (disturb && i == 3) begin
                start = 1'b1; op = 2'b10; a = 8'h00; b = 8'hAA;
            end
            if (disturb && i == 4) start = 1'b0;
            tick();
            chk({tag, "_busy_run"}, busy, 1);
            chk({tag, "_done_run"}, done, 0);
            chk({tag, "_y_hold"}, y, prev_y);
        end
        tick();
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_y"}, y, exp);
        tick();
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        tick();
        chk({tag, "_no_accept"}, busy, 0);
        chk({tag, "_one_done"}, donecnt, d0 + 1);
        prev_y = exp;
    endtask

    initial begin
        int pulses;
        int t[3];
        int d0;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        prev_y = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        run_cmd(2'b00, 8'hA5, 8'h00, 8'h5A, 1'b0, "not_a5");
        run_cmd(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
        run_cmd(2'b10, 8'hF0, 8'h3C, 8'hFC, 1'b0, "or");
        run_cmd(2'b11, 8'hF0, 8'h3C, 8'hCC, 1'b0, "xor");
        run_cmd(2'b10, 8'hF0, 8'h3C, 8'hFC, 1'b0, "or2");
        run_cmd(2'b01, 8'hFF, 8'h0F, 8'h0F, 1'b1, "and_disturb");

        // Continuous start: pulses must be WIDTH+2 = 10 cycles apart.
        pulses = 0;
        start = 1'b1; op = 2'b11; a = 8'h55; b = 8'hFF;
        for (int n = 0; n < 40 && pulses < 3; n++) begin
            tick();
            if (done === 1'b1) begin
                t[pulses] = n;
                pulses++;
                chk("cont_y", y, 8'hAA);
                if (pulses == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("cont_pulses", pulses, 3);
        chk("cont_first", t[0], 8);
        chk("cont_gap1", t[1] - t[0], 10);
        chk("cont_gap2", t[2] - t[1], 10);
        tick();
        tick();
        chk("cont_idle", busy, 0);

        // Reset during RUN at bit 3 of an op following y=0x30.
        prev_y = 8'hAA;
        run_cmd(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, "pre_rst");
        d0 = donecnt;
        start = 1'b1; op = 2'b10; a = 8'h0F; b = 8'hF0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", busy, 1);
        chk("mid_y", y, 8'h30);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_y", y, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", donecnt, d0);
        chk("abort_idle", busy, 0);
        prev_y = 8'h00;
        run_cmd(2'b00, 8'h00, 8'h00, 8'hFF, 1'b0, "not_00");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
